uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Standalone UART receiver with 3-sample majority vote, optional even parity, framing/parity/overrun detection and a small output FIFO with a valid/ready handshake. It is the receive end of the link driven by the `my_uart` transmitter and uses the same `PSCALER`/`DIV` bit-timing scheme, so both ends agree on baud rate by construction. It sits between the `rx` pad (asynchronous) and any byte consumer in the `sysclk` domain.

## Interface
- `N`, 8: data bits per frame, LSB first.
- `PSCALER`, 4: sysclk cycles per sample tick.
- `DIV`, 10: ticks per bit, ≥4; bit period = `PSCALER*DIV` cycles.
- `DEPTH`, 4: FIFO entries, power of two ≥2.

Ports:
- `sysclk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `parity_i` in 1: 0 = no parity bit; 1 = even parity bit after data.
- `rx_i` in 1: serial input, asynchronous, idle high.
- `data_o` out N: FIFO head byte.
- `valid_o` out 1: FIFO not empty.
- `ready_i` in 1: consumer pops head when `valid_o & ready_i` at a rising edge.
- `frame_err_o` out 1: 1-cycle pulse, stop bit sampled 0.
- `parity_err_o` out 1: 1-cycle pulse, parity mismatch.
- `overrun_o` out 1: 1-cycle pulse, good byte dropped because FIFO full.

## Operation
- `rx_i` is passed through a 2-flop synchronizer (`rx_s`), which resets to 1. All decisions use `rx_s`.
- Counters:
  - Prescaler 0..`PSCALER`-1; `tick` asserts when it wraps.
  - Tick counter 0..`DIV`-1 within a bit.
  - Bit index 0..N-1.
  - All three are cleared on start detection.
- Sampling: within each bit, `rx_s` is sampled at tick indices `DIV/2-1`, `DIV/2`, `DIV/2+1` (integer division). The bit value is the majority of the 3 samples, decided at tick `DIV/2+1`.
- State machine:
  - IDLE → START on a 1→0 transition of `rx_s`. A line that stays low, e.g. a break, never retriggers.
  - START: majority = 1 → IDLE (false start, no flags). Otherwise wait until tick `DIV-1` → DATA.
  - DATA: shift the majority value into bit index (LSB first). After bit N-1 ends → PARITY if `parity_i`, else STOP.
  - PARITY: expected value is the XOR of the data bits. Compare at the decision point; latch the mismatch; → STOP at bit end.
  - STOP: at the decision point:
    - Majority 0 → `frame_err_o` pulse, no push.
    - Else, parity mismatch → `parity_err_o` pulse, no push.
    - Else push to the FIFO, or `overrun_o` pulse if full.
    - Return to IDLE in the same cycle; start detection is armed from the next cycle, i.e. mid stop bit.
- `parity_i` is sampled at start detection and held for the frame.
- FIFO:
  - Push and pop in the same cycle are both performed, even when full (count unchanged, push accepted).
  - A pop when empty is ignored.
  - `data_o` is registered from the head pointer; storage is not reset.
  - Bytes leave in arrival order.
- Error and overrun flags never enter the FIFO.

## Timing
- Reset values: `data_o`=0, `valid_o`=0, all error pulses 0, state IDLE, FIFO empty, counters 0.
- Reset assertion mid-frame aborts immediately. After release, the receiver waits for a fresh 1→0 edge.
- Start detection occurs 2 cycles after the `rx_i` falling edge (synchronizer delay).
- Decision point of bit k (start = bit 0) is at cycle `k*PSCALER*DIV + PSCALER*(DIV/2+2)` after start detection, ±0 cycles.
- Push and error pulses are registered on the cycle after the stop decision. `valid_o` and the new `data_o` are visible the cycle after the push; this is 2 cycles after the stop decision.
- A glitch shorter than `PSCALER*(DIV/2-1)` cycles low is always rejected as a false start.
- Back-to-back frames with a 1-bit stop and zero idle gap must be received without loss.

## Test plan
All scenarios use `PSCALER`=4, `DIV`=10, i.e. 40 cycles/bit.
- **Basic frame:** frame 0x55, `parity_i`=0, `ready_i`=1 → `valid_o` high for 1 cycle with `data_o`=0x55; no error pulses.
- **Parity:** `parity_i`=1, byte 0xA3 with parity bit 1 → `parity_err_o` single pulse, `valid_o` stays 0. Then 0xA3 with parity bit 0 → `data_o`=0xA3.
- **Framing error:** 0x3C with stop bit 0 (line held low 2 bit times, then high) → `frame_err_o` single pulse, no push, no retrigger while low. Next valid frame 0x81 → `data_o`=0x81.
- **Glitch rejection:** `rx_i` low for 8 cycles, then high → no state change, no pulses, `valid_o`=0.
- **Overrun and ordering:** `ready_i`=0, 5 back-to-back frames 0x01..0x05 → `valid_o`=1 after the first; `overrun_o` pulses once on the 5th. Then `ready_i`=1 → `data_o` sequence 0x01, 0x02, 0x03, 0x04, then `valid_o`=0. Include one cycle where push and pop coincide while full.
- **Reset mid-frame:** `reset_n`=0 during data bit 3 of 0xF0 → all outputs at reset values. After release, frame 0x5A → `data_o`=0x5A; no spurious byte or error.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream side of the UART receiver: FIFO head with valid/ready plus
// the per-frame error pulses.
interface uart_rx_fifo_if #(parameter int N = 8);
    logic [N-1:0] data_o;
    logic         valid_o;
    logic         ready_i;
    logic         frame_err_o;
    logic         parity_err_o;
    logic         overrun_o;

    modport master (
        output data_o, valid_o, frame_err_o, parity_err_o, overrun_o,
        input  ready_i
    );

    modport slave (
        input  data_o, valid_o, frame_err_o, parity_err_o, overrun_o,
        output ready_i
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchronizer, 3-sample majority per bit, optional
// even parity, frame/parity/overrun pulses and a small output FIFO.
module uart_rx_fifo #(
    parameter int N       = 8,
    parameter int PSCALER = 4,
    parameter int DIV     = 10,
    parameter int DEPTH   = 4
) (
    input  logic sysclk,
    input  logic reset_n,
    input  logic parity_i,
    input  logic rx_i,
    uart_rx_fifo_if.master out_if
);
    localparam int PW = (PSCALER > 1) ? $clog2(PSCALER) : 1;
    localparam int TW = $clog2(DIV);
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PSCALER - 1);
    localparam logic [TW-1:0] T_S0     = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] T_S1     = TW'(DIV / 2);
    localparam logic [TW-1:0] T_DEC    = TW'(DIV / 2 + 1);
    localparam logic [TW-1:0] T_LAST   = TW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // synchronizer / edge detect
    logic       rx_s1_q, rx_s1_d, rx_s_q, rx_s_d, rx_hi_q, rx_hi_d;
    logic [1:0] sync_vld_q, sync_vld_d;
    logic       start_edge;

    // receive path
    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            s0_q, s0_d, s1_q, s1_d;
    logic [N-1:0]    shift_q, shift_d;
    logic            par_en_q, par_en_d, par_err_q, par_err_d;
    logic            frame_err_q, frame_err_d, parity_err_q, parity_err_d;
    logic            push_q, push_d;
    logic            tick, decide, bit_end, maj;

    // FIFO
    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  data_q, data_d;
    logic          full, valid, pop, do_push, overrun;

    // rx_hi only goes high once a real (post-reset) high level has been
    // seen, so a line held low across reset release never looks like a start.
    always_comb begin
        rx_s1_d    = rx_i;
        rx_s_d     = rx_s1_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
        rx_hi_d    = rx_s_q & sync_vld_q[1];
        start_edge = rx_hi_q & ~rx_s_q;
    end

    // synchronizer registers
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            sync_vld_q <= '0;
            rx_hi_q    <= 1'b0;
        end else begin
            rx_s1_q    <= rx_s1_d;
            rx_s_q     <= rx_s_d;
            sync_vld_q <= sync_vld_d;
            rx_hi_q    <= rx_hi_d;
        end
    end

    // bit timing, majority sampling and frame state machine
    always_comb begin
        tick    = (pre_q == PRE_LAST);
        decide  = tick && (tcnt_q == T_DEC);
        bit_end = tick && (tcnt_q == T_LAST);
        maj     = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);

        state_d      = state_q;
        pre_d        = tick ? '0 : pre_q + PW'(1);
        tcnt_d       = bit_end ? '0 : (tick ? tcnt_q + TW'(1) : tcnt_q);
        bit_d        = bit_q;
        s0_d         = s0_q;
        s1_d         = s1_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_err_d    = par_err_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        push_d       = 1'b0;

        if (tick && tcnt_q == T_S0) s0_d = rx_s_q;
        if (tick && tcnt_q == T_S1) s1_d = rx_s_q;

        case (state_q)
            IDLE: begin
                pre_d  = '0;
                tcnt_d = '0;
                bit_d  = '0;
                if (start_edge) begin
                    state_d   = START;
                    par_en_d  = parity_i;
                    par_err_d = 1'b0;
                end
            end
            START: begin
                if (decide && maj) state_d = IDLE;
                else if (bit_end)  state_d = DATA;
            end
            DATA: begin
                if (decide) shift_d[bit_q] = maj;
                if (bit_end) begin
                    if (bit_q == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
                    else                   bit_d   = bit_q + BW'(1);
                end
            end
            PARITY: begin
                if (decide)  par_err_d = maj ^ (^shift_q);
                if (bit_end) state_d   = STOP;
            end
            STOP: begin
                if (decide) begin
                    state_d = IDLE;
                    if (!maj)          frame_err_d  = 1'b1;
                    else if (par_err_q) parity_err_d = 1'b1;
                    else               push_d       = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // receive path registers
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pre_q        <= '0;
            tcnt_q       <= '0;
            bit_q        <= '0;
            s0_q         <= 1'b0;
            s1_q         <= 1'b0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            push_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            tcnt_q       <= tcnt_d;
            bit_q        <= bit_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_err_q    <= par_err_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            push_q       <= push_d;
        end
    end

    // FIFO control; overrun is resolved at push time so that a pop in the
    // same cycle still makes room. The head register bypasses the write
    // when the pushed entry becomes the head.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        valid    = (count_q != '0);
        pop      = valid & out_if.ready_i;
        do_push  = push_q & (~full | pop);
        overrun  = push_q & full & ~pop;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(do_push) - CW'(pop);
        data_d   = data_q;
        if (count_d != '0)
            data_d = (do_push && wr_ptr_q == rd_ptr_d) ? shift_q : mem_q[rd_ptr_d];
    end

    // FIFO pointers and head register
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end

    // FIFO storage, intentionally not reset
    always_ff @(posedge sysclk) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign out_if.data_o       = data_q;
    assign out_if.valid_o      = valid;
    assign out_if.frame_err_o  = frame_err_q;
    assign out_if.parity_err_o = parity_err_q;
    assign out_if.overrun_o    = overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at PSCALER=4, DIV=10 (40 cycles/bit).
module tb_uart_rx_fifo;
    localparam int BIT = 40;

    logic sysclk = 1'b0;
    logic reset_n, parity_i, rx_i;
    uart_rx_fifo_if #(.N(8)) bus ();

    uart_rx_fifo #(.N(8), .PSCALER(4), .DIV(10), .DEPTH(4)) dut (
        .sysclk(sysclk), .reset_n(reset_n), .parity_i(parity_i),
        .rx_i(rx_i), .out_if(bus)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0, n_err = 0;
    int cyc = 0, last_start = 0, vrise = -1;
    int n_vcyc = 0, n_ferr = 0, n_perr = 0, n_ovr = 0, ferr_cyc = -1, perr_cyc = -1;
    logic vprev = 1'b0;
    logic [7:0] popped [$];

    always @(posedge sysclk) cyc++;

    // output monitor, sampled mid-cycle
    always @(negedge sysclk) begin
        if (bus.valid_o && !vprev) vrise = cyc;
        vprev = bus.valid_o;
        if (bus.valid_o) n_vcyc++;
        if (bus.frame_err_o)  begin n_ferr++; ferr_cyc = cyc; end
        if (bus.parity_err_o) begin n_perr++; perr_cyc = cyc; end
        if (bus.overrun_o) n_ovr++;
        if (bus.valid_o && bus.ready_i) popped.push_back(bus.data_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic clr();
        popped.delete();
        n_vcyc = 0; n_ferr = 0; n_perr = 0; n_ovr = 0;
        vrise = -1; ferr_cyc = -1; perr_cyc = -1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input bit pbit, input bit stopv);
        rx_i = 1'b0;
        last_start = cyc;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            wait_cyc(BIT);
        end
        if (par) begin
            rx_i = pbit;
            wait_cyc(BIT);
        end
        rx_i = stopv;
        wait_cyc(BIT);
    endtask

    initial begin
        reset_n = 1'b0; rx_i = 1'b1; parity_i = 1'b0; bus.ready_i = 1'b0;
        wait_cyc(3);
        chk("rst_data", 32'(bus.data_o), 0);
        chk("rst_valid", 32'(bus.valid_o), 0);
        chk("rst_pulses", 32'({bus.frame_err_o, bus.parity_err_o, bus.overrun_o}), 0);
        reset_n = 1'b1;
        wait_cyc(10);

        // basic frame
        clr(); bus.ready_i = 1'b1;
        send_frame(8'h55, 0, 0, 1);
        wait_cyc(BIT);
        chk("basic_latency", 32'(vrise - last_start), 392);
        chk("basic_vcyc", 32'(n_vcyc), 1);
        chk("basic_npop", 32'(popped.size()), 1);
        if (popped.size() > 0) chk("basic_data", 32'(popped[0]), 32'h55);
        chk("basic_errs", 32'(n_ferr + n_perr + n_ovr), 0);

        // parity: 0xA3 has four ones, so the even parity bit is 0
        clr(); parity_i = 1'b1;
        send_frame(8'hA3, 1, 1, 1);
        wait_cyc(BIT);
        chk("par_bad_n", 32'(n_perr), 1);
        chk("par_bad_cyc", 32'(perr_cyc - last_start), 431);
        chk("par_bad_vcyc", 32'(n_vcyc), 0);
        clr();
        send_frame(8'hA3, 1, 0, 1);
        wait_cyc(BIT);
        chk("par_ok_latency", 32'(vrise - last_start), 432);
        chk("par_ok_npop", 32'(popped.size()), 1);
        if (popped.size() > 0) chk("par_ok_data", 32'(popped[0]), 32'hA3);
        chk("par_ok_perr", 32'(n_perr), 0);
        parity_i = 1'b0;

        // framing error: stop low, line held low a further bit time
        clr();
        send_frame(8'h3C, 0, 0, 0);
        wait_cyc(BIT);
        chk("frm_n", 32'(n_ferr), 1);
        chk("frm_cyc", 32'(ferr_cyc - last_start), 391);
        rx_i = 1'b1;
        wait_cyc(2 * BIT);
        chk("frm_no_retrig", 32'(n_ferr + n_perr), 1);
        chk("frm_no_push", 32'(n_vcyc), 0);
        clr();
        send_frame(8'h81, 0, 0, 1);
        wait_cyc(BIT);
        chk("frm_next_npop", 32'(popped.size()), 1);
        if (popped.size() > 0) chk("frm_next_data", 32'(popped[0]), 32'h81);

        // glitch rejection
        clr();
        rx_i = 1'b0; wait_cyc(8);
        rx_i = 1'b1; wait_cyc(3 * BIT);
        chk("glitch_pulses", 32'(n_ferr + n_perr + n_ovr), 0);
        chk("glitch_vcyc", 32'(n_vcyc), 0);

        // overrun and ordering
        clr(); bus.ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 0, 0, 1);
            if (i == 1) chk("ovr_valid_first", 32'(bus.valid_o), 1);
        end
        wait_cyc(BIT);
        chk("ovr_n", 32'(n_ovr), 1);
        chk("ovr_head", 32'(bus.data_o), 32'h01);
        bus.ready_i = 1'b1;
        wait_cyc(10);
        chk("ovr_npop", 32'(popped.size()), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++)
            chk($sformatf("ovr_pop%0d", i), 32'(popped[i]), 32'(i + 1));
        chk("ovr_drained", 32'(bus.valid_o), 0);

        // push and pop in the same cycle while full
        clr(); bus.ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 0, 0, 1);
        fork
            send_frame(8'h15, 0, 0, 1);
            begin
                wait_cyc(391);
                bus.ready_i = 1'b1;
                wait_cyc(1);
                bus.ready_i = 1'b0;
            end
        join
        wait_cyc(BIT);
        chk("coin_ovr", 32'(n_ovr), 0);
        chk("coin_npop", 32'(popped.size()), 1);
        bus.ready_i = 1'b1;
        wait_cyc(10);
        chk("coin_npop_all", 32'(popped.size()), 5);
        for (int i = 0; i < 5 && i < popped.size(); i++)
            chk($sformatf("coin_pop%0d", i), 32'(popped[i]), 32'h11 + 32'(i));

        // reset during data bit 3 of 0xF0
        clr();
        rx_i = 1'b0;
        wait_cyc(4 * BIT + BIT / 2);
        reset_n = 1'b0;
        wait_cyc(3);
        chk("mid_rst_data", 32'(bus.data_o), 0);
        chk("mid_rst_valid", 32'(bus.valid_o), 0);
        chk("mid_rst_pulses", 32'({bus.frame_err_o, bus.parity_err_o, bus.overrun_o}), 0);
        reset_n = 1'b1;
        wait_cyc(BIT / 2 - 3);
        rx_i = 1'b1;
        wait_cyc(6 * BIT);
        send_frame(8'h5A, 0, 0, 1);
        wait_cyc(BIT);
        chk("post_rst_npop", 32'(popped.size()), 1);
        if (popped.size() > 0) chk("post_rst_data", 32'(popped[0]), 32'h5A);
        chk("post_rst_errs", 32'(n_ferr + n_perr + n_ovr), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
